// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg
//   Shared definitions for the SRAM port arbiter.
//   - owner_e    : registered owner encoding (NONE/LD/CPU/SPI)
//   - RQ_*       : requester bit positions inside the 3-bit GNT/RVLD vectors
package sram_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_LD   = 2'd1,
        OWN_CPU  = 2'd2,
        OWN_SPI  = 2'd3
    } owner_e;

    localparam int RQ_LD  = 0;
    localparam int RQ_CPU = 1;
    localparam int RQ_SPI = 2;

endpackage

// File: rtl/sram_arb_starve_cnt.sv
// sram_arb_starve_cnt
//   Saturating CPU starvation counter.
//   Ports:
//     CLK  in  clock, state on rising edge
//     RST  in  synchronous active-high reset
//     inc  in  CPU is requesting and was not granted this cycle
//     clr  in  CPU was granted this cycle
//     sat  out counter has reached MAX
module sram_arb_starve_cnt #(
    parameter int MAX = 7
) (
    input  logic CLK,
    input  logic RST,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam logic [7:0] SAT_VAL = 8'(MAX);

    logic [7:0] cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt <= 8'd0;
        end else if (clr) begin
            cnt <= 8'd0;
        end else if (inc && !sat) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign sat = (cnt == SAT_VAL);

endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares one single-port SRAM between the scan loader (LD), the serial
//   CPU (CPU) and the pseudo-SPI readout (SPI).
//   Ports:
//     CLK, RST                      clock, synchronous active-high reset
//     LD_REQ/WE/A/D,  LD_GNT        loader request and access strobe
//     CPU_REQ/WE/A/D, CPU_GNT       CPU request and access strobe
//     SPI_REQ/A,      SPI_GNT       SPI read-only burst request and strobe
//     RVLD[2:0], RDATA              {SPI,CPU,LD} read-data valid + data
//     SRAM_CEN/WEN/A/D, SRAM_Q      SRAM macro pins (CEN/WEN active-low)
//     OWNER                         debug view of the owner FSM state
//
//   Handshake: REQ acts as valid; GNT means the access is issued on the SRAM
//   pins in that same cycle. A requester keeps REQ, A, D and WE stable until
//   it sees GNT; the arbiter never latches a request it has not granted.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 8,
    parameter int STARVE_MAX = 7
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              LD_REQ,
    input  logic              LD_WE,
    input  logic [ADDR_W-1:0] LD_A,
    input  logic [DATA_W-1:0] LD_D,
    output logic              LD_GNT,
    input  logic              CPU_REQ,
    input  logic              CPU_WE,
    input  logic [ADDR_W-1:0] CPU_A,
    input  logic [DATA_W-1:0] CPU_D,
    output logic              CPU_GNT,
    input  logic              SPI_REQ,
    input  logic [ADDR_W-1:0] SPI_A,
    output logic              SPI_GNT,
    output logic [2:0]        RVLD,
    output logic [DATA_W-1:0] RDATA,
    output logic              SRAM_CEN,
    output logic              SRAM_WEN,
    output logic [ADDR_W-1:0] SRAM_A,
    output logic [DATA_W-1:0] SRAM_D,
    input  logic [DATA_W-1:0] SRAM_Q,
    output owner_e            OWNER
);

    owner_e            owner;
    logic [2:0]        rvld_q;
    logic [DATA_W-1:0] rdata_q;
    logic [ADDR_W-1:0] a_q;
    logic [DATA_W-1:0] d_q;

    logic              starve_sat;
    logic              spi_lock;
    logic              ld_gnt, cpu_gnt, spi_gnt;
    logic              cen_c, wen_c;
    logic [ADDR_W-1:0] a_c;
    logic [DATA_W-1:0] d_c;

    sram_arb_starve_cnt #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .CLK (CLK),
        .RST (RST),
        .inc (CPU_REQ && !cpu_gnt),
        .clr (cpu_gnt),
        .sat (starve_sat)
    );

    // Priority: LD always; then an SPI burst in progress keeps the port
    // until the CPU has waited STARVE_MAX cycles; then the CPU unless a new
    // SPI burst is asking; then SPI. Grants are held off during reset.
    always_comb begin
        spi_lock = (owner == OWN_SPI) && SPI_REQ && !starve_sat;
        ld_gnt   = !RST && LD_REQ;
        cpu_gnt  = !RST && !LD_REQ && !spi_lock && CPU_REQ &&
                   !(SPI_REQ && (owner != OWN_SPI));
        spi_gnt  = !RST && !LD_REQ && SPI_REQ && !cpu_gnt;
    end

    // SRAM pin mux; without a grant the address/data buses keep their
    // last driven value so the macro inputs do not toggle needlessly.
    always_comb begin
        cen_c = 1'b1;
        wen_c = 1'b1;
        a_c   = a_q;
        d_c   = d_q;
        if (ld_gnt) begin
            cen_c = 1'b0;
            wen_c = !LD_WE;
            a_c   = LD_A;
            d_c   = LD_D;
        end else if (cpu_gnt) begin
            cen_c = 1'b0;
            wen_c = !CPU_WE;
            a_c   = CPU_A;
            d_c   = CPU_D;
        end else if (spi_gnt) begin
            cen_c = 1'b0;
            a_c   = SPI_A;
        end
    end

    // Owner FSM plus the registered read-valid / hold state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            owner   <= OWN_NONE;
            rvld_q  <= 3'b000;
            rdata_q <= '0;
            a_q     <= '0;
            d_q     <= '0;
        end else begin
            if (ld_gnt) begin
                owner <= OWN_LD;
            end else if (cpu_gnt) begin
                owner <= OWN_CPU;
            end else if (spi_gnt) begin
                owner <= OWN_SPI;
            end else begin
                owner <= OWN_NONE;
            end
            rvld_q[RQ_LD]  <= ld_gnt && !LD_WE;
            rvld_q[RQ_CPU] <= cpu_gnt && !CPU_WE;
            rvld_q[RQ_SPI] <= spi_gnt;
            if (|rvld_q) begin
                rdata_q <= SRAM_Q;
            end
            a_q <= a_c;
            d_q <= d_c;
        end
    end

    assign LD_GNT   = ld_gnt;
    assign CPU_GNT  = cpu_gnt;
    assign SPI_GNT  = spi_gnt;
    assign SRAM_CEN = cen_c;
    assign SRAM_WEN = wen_c;
    // Reset is visible on the outputs in the cycle RST is high, which also
    // kills an RVLD left over from a read granted just before reset.
    assign SRAM_A   = RST ? '0 : a_c;
    assign SRAM_D   = RST ? '0 : d_c;
    assign RVLD     = RST ? 3'b000 : rvld_q;
    // The macro presents Q in the cycle after the read, so the valid cycle
    // passes it straight through and rdata_q holds it afterwards.
    assign RDATA    = RST ? '0 : ((|rvld_q) ? SRAM_Q : rdata_q);
    assign OWNER    = RST ? OWN_NONE : owner;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter
//   Directed bench: a table of single-cycle vectors for reset, CPU read,
//   LD/CPU collision, read-back and reset after a read, then hand-written
//   sequences for SPI starvation pre-emption and LD interrupting a burst.
module tb_sram_port_arbiter;
    import sram_arb_pkg::*;

    logic        clk;
    logic        rst;
    logic        ld_req, ld_we, cpu_req, cpu_we, spi_req;
    logic [9:0]  ld_a, cpu_a, spi_a;
    logic [7:0]  ld_d, cpu_d;
    logic        ld_gnt, cpu_gnt, spi_gnt;
    logic [2:0]  rvld;
    logic [7:0]  rdata;
    logic        sram_cen, sram_wen;
    logic [9:0]  sram_a;
    logic [7:0]  sram_d, sram_q;
    owner_e      owner;

    int n_vec = 0;
    int n_miscmp = 0;
    logic [10:0] exp_q[$];
    logic [7:0]  mem [1024];

    sram_port_arbiter #(.ADDR_W(10), .DATA_W(8), .STARVE_MAX(7)) dut (
        .CLK(clk), .RST(rst),
        .LD_REQ(ld_req), .LD_WE(ld_we), .LD_A(ld_a), .LD_D(ld_d), .LD_GNT(ld_gnt),
        .CPU_REQ(cpu_req), .CPU_WE(cpu_we), .CPU_A(cpu_a), .CPU_D(cpu_d), .CPU_GNT(cpu_gnt),
        .SPI_REQ(spi_req), .SPI_A(spi_a), .SPI_GNT(spi_gnt),
        .RVLD(rvld), .RDATA(rdata),
        .SRAM_CEN(sram_cen), .SRAM_WEN(sram_wen), .SRAM_A(sram_a), .SRAM_D(sram_d),
        .SRAM_Q(sram_q), .OWNER(owner)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    function automatic logic [7:0] pat(input logic [9:0] a);
        return a[7:0] ^ 8'h3C;
    endfunction

    // Behavioural 1Kx8 SRAM macro: registered read, Q valid next cycle.
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = pat(10'(i));
        mem[5] = 8'hA5;
        sram_q = 8'h00;
        forever begin
            @(posedge clk);
            if (!sram_cen) begin
                if (!sram_wen) mem[sram_a] <= sram_d;
                else           sram_q <= mem[sram_a];
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic       rst;
        logic       ld_req, ld_we;   logic [9:0] ld_a;  logic [7:0] ld_d;
        logic       cpu_req, cpu_we; logic [9:0] cpu_a; logic [7:0] cpu_d;
        logic       spi_req;         logic [9:0] spi_a;
        logic [2:0] e_gnt;
        logic       e_cen, e_wen;
        logic [9:0] e_a;
        logic [7:0] e_d;
        logic [2:0] e_rvld;
        logic [7:0] e_rdata;
        logic [1:0] e_owner;
    } vec_t;

    vec_t tbl [11];

    function automatic vec_t mk(
        input logic r,
        input logic lr, input logic lw, input logic [9:0] la, input logic [7:0] ldd,
        input logic cr, input logic cw, input logic [9:0] ca, input logic [7:0] cd,
        input logic sr, input logic [9:0] sa,
        input logic [2:0] eg, input logic ec, input logic ew, input logic [9:0] ea,
        input logic [7:0] ed, input logic [2:0] ev, input logic [7:0] er, input logic [1:0] eo);
        vec_t v;
        v.rst = r;
        v.ld_req = lr;  v.ld_we = lw;  v.ld_a = la;  v.ld_d = ldd;
        v.cpu_req = cr; v.cpu_we = cw; v.cpu_a = ca; v.cpu_d = cd;
        v.spi_req = sr; v.spi_a = sa;
        v.e_gnt = eg; v.e_cen = ec; v.e_wen = ew; v.e_a = ea; v.e_d = ed;
        v.e_rvld = ev; v.e_rdata = er; v.e_owner = eo;
        return v;
    endfunction

    // ---------------- driver / checker tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        rst = 1'b0;
        ld_req = 1'b0;  ld_we = 1'b0;  ld_a = '0;  ld_d = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_a = '0; cpu_d = '0;
        spi_req = 1'b0; spi_a = '0;
    endtask

    task automatic drive_vec(input vec_t v);
        rst = v.rst;
        ld_req = v.ld_req;   ld_we = v.ld_we;   ld_a = v.ld_a;   ld_d = v.ld_d;
        cpu_req = v.cpu_req; cpu_we = v.cpu_we; cpu_a = v.cpu_a; cpu_d = v.cpu_d;
        spi_req = v.spi_req; spi_a = v.spi_a;
    endtask

    task automatic check_vec(input int idx, input vec_t v);
        string t;
        t = $sformatf("row%0d", idx);
        check({t, " gnt"},   32'({spi_gnt, cpu_gnt, ld_gnt}), 32'(v.e_gnt));
        check({t, " cen"},   32'(sram_cen), 32'(v.e_cen));
        check({t, " wen"},   32'(sram_wen), 32'(v.e_wen));
        check({t, " addr"},  32'(sram_a),   32'(v.e_a));
        check({t, " wdata"}, 32'(sram_d),   32'(v.e_d));
        check({t, " rvld"},  32'(rvld),     32'(v.e_rvld));
        check({t, " owner"}, 32'(owner),    32'(v.e_owner));
        if (v.e_rvld != 3'b000 || v.rst) check({t, " rdata"}, 32'(rdata), 32'(v.e_rdata));
    endtask

    // One sequence cycle: score last cycle's read, check this cycle's access,
    // queue the read data this access should return.
    task automatic seq_cycle(input string tag, input logic [2:0] e_g, input logic [9:0] e_a,
                             input logic e_wen, input logic chk_d, input logic [7:0] e_d,
                             input logic [7:0] e_rd);
        logic [10:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, " rvld"},  32'(rvld),  32'(e[10:8]));
            check({tag, " rdata"}, 32'(rdata), 32'(e[7:0]));
        end else begin
            check({tag, " rvld idle"}, 32'(rvld), 32'(0));
        end
        check({tag, " gnt"},  32'({spi_gnt, cpu_gnt, ld_gnt}), 32'(e_g));
        check({tag, " cen"},  32'(sram_cen), 32'(e_g == 3'b000));
        check({tag, " wen"},  32'(sram_wen), 32'(e_wen));
        check({tag, " addr"}, 32'(sram_a),   32'(e_a));
        if (chk_d) check({tag, " wdata"}, 32'(sram_d), 32'(e_d));
        if (e_g != 3'b000 && e_wen) exp_q.push_back({e_g, e_rd});
    endtask

    // ---------------- main test ----------------
    int          done, ld_done, beat;
    logic        cpu_done, saw_spi, saw_cpu, saw_ld;
    logic [2:0]  e_g;
    logic [9:0]  e_a;
    logic [7:0]  e_rd, e_d;
    logic        e_wen, chk_d;

    initial begin
        //              rst  ld: req we a      d      cpu: req we a      d      spi: req a      gnt    cen  wen  a       d      rvld   rdata  owner
        tbl[0]  = mk(1'b1, 1'b1,1'b1,10'h010,8'h33, 1'b1,1'b0,10'h005,8'h00, 1'b1,10'h020, 3'b000,1'b1,1'b1,10'h000,8'h00, 3'b000,8'h00, 2'd0);
        tbl[1]  = mk(1'b0, 1'b1,1'b1,10'h010,8'h33, 1'b1,1'b0,10'h005,8'h00, 1'b1,10'h020, 3'b001,1'b0,1'b0,10'h010,8'h33, 3'b000,8'h00, 2'd0);
        tbl[2]  = mk(1'b0, 1'b0,1'b0,10'h000,8'h00, 1'b1,1'b0,10'h005,8'h00, 1'b0,10'h000, 3'b010,1'b0,1'b1,10'h005,8'h00, 3'b000,8'h00, 2'd1);
        tbl[3]  = mk(1'b0, 1'b0,1'b0,10'h000,8'h00, 1'b0,1'b0,10'h000,8'h00, 1'b0,10'h000, 3'b000,1'b1,1'b1,10'h005,8'h00, 3'b010,8'hA5, 2'd2);
        tbl[4]  = mk(1'b0, 1'b1,1'b1,10'h3FF,8'h11, 1'b1,1'b1,10'h3FF,8'h22, 1'b0,10'h000, 3'b001,1'b0,1'b0,10'h3FF,8'h11, 3'b000,8'h00, 2'd0);
        tbl[5]  = mk(1'b0, 1'b0,1'b0,10'h000,8'h00, 1'b1,1'b1,10'h3FF,8'h22, 1'b0,10'h000, 3'b010,1'b0,1'b0,10'h3FF,8'h22, 3'b000,8'h00, 2'd1);
        tbl[6]  = mk(1'b0, 1'b0,1'b0,10'h000,8'h00, 1'b1,1'b0,10'h3FF,8'h22, 1'b0,10'h000, 3'b010,1'b0,1'b1,10'h3FF,8'h22, 3'b000,8'h00, 2'd2);
        tbl[7]  = mk(1'b0, 1'b0,1'b0,10'h000,8'h00, 1'b0,1'b0,10'h000,8'h00, 1'b0,10'h000, 3'b000,1'b1,1'b1,10'h3FF,8'h22, 3'b010,8'h22, 2'd2);
        tbl[8]  = mk(1'b0, 1'b0,1'b0,10'h000,8'h00, 1'b1,1'b0,10'h005,8'h00, 1'b0,10'h000, 3'b010,1'b0,1'b1,10'h005,8'h00, 3'b000,8'h00, 2'd0);
        tbl[9]  = mk(1'b1, 1'b0,1'b0,10'h000,8'h00, 1'b1,1'b0,10'h005,8'h00, 1'b0,10'h000, 3'b000,1'b1,1'b1,10'h000,8'h00, 3'b000,8'h00, 2'd0);
        tbl[10] = mk(1'b0, 1'b0,1'b0,10'h000,8'h00, 1'b0,1'b0,10'h000,8'h00, 1'b0,10'h000, 3'b000,1'b1,1'b1,10'h000,8'h00, 3'b000,8'h00, 2'd0);

        drive_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) begin
            drive_vec(tbl[i]);
            @(negedge clk);
            check_vec(i, tbl[i]);
            @(posedge clk);
            #1;
        end
        drive_idle();

        // SPI 20-beat burst from 0x100; CPU read of 0x005 raised at cycle 3.
        // CPU wins exactly at cycle 10, SPI resumes at the same address.
        done = 0;
        cpu_done = 1'b0;
        for (int c = 0; c < 24; c++) begin
            spi_req = (done < 20);
            spi_a   = 10'h100 + 10'(done);
            cpu_req = (c >= 3) && !cpu_done;
            cpu_we  = 1'b0;
            cpu_a   = 10'h005;
            cpu_d   = 8'h00;
            @(negedge clk);
            saw_spi = spi_gnt;
            saw_cpu = cpu_gnt;
            e_rd = 8'h00;
            if (c == 10) begin
                e_g = 3'b010; e_a = 10'h005; e_rd = 8'hA5;
            end else if (c < 21) begin
                beat = (c < 10) ? c : c - 1;
                e_g = 3'b100; e_a = 10'h100 + 10'(beat); e_rd = pat(e_a);
            end else begin
                e_g = 3'b000; e_a = 10'h113;
            end
            seq_cycle($sformatf("starve c%0d", c), e_g, e_a, 1'b1, 1'b0, 8'h00, e_rd);
            @(posedge clk);
            #1;
            if (saw_spi) done++;
            if (saw_cpu) cpu_done = 1'b1;
        end
        drive_idle();

        // SPI burst from 0x140 interrupted by a 3-beat LD write at cycle 2;
        // SPI then finishes its 4 beats and drops REQ.
        done = 0;
        ld_done = 0;
        for (int c = 0; c < 10; c++) begin
            ld_req  = (c >= 2) && (ld_done < 3);
            ld_we   = 1'b1;
            ld_a    = 10'h200 + 10'(ld_done);
            ld_d    = 8'hC0 + 8'(ld_done);
            spi_req = (done < 4);
            spi_a   = 10'h140 + 10'(done);
            @(negedge clk);
            saw_spi = spi_gnt;
            saw_ld  = ld_gnt;
            e_rd = 8'h00;
            e_d  = 8'h00;
            if (c >= 2 && c <= 4) begin
                e_g = 3'b001; e_a = 10'h200 + 10'(c - 2); e_wen = 1'b0;
                chk_d = 1'b1; e_d = 8'hC0 + 8'(c - 2);
            end else if (c < 7) begin
                beat = (c < 2) ? c : c - 3;
                e_g = 3'b100; e_a = 10'h140 + 10'(beat); e_wen = 1'b1;
                chk_d = 1'b0; e_rd = pat(e_a);
            end else begin
                e_g = 3'b000; e_a = 10'h143; e_wen = 1'b1;
                chk_d = 1'b1; e_d = 8'hC2;
            end
            seq_cycle($sformatf("ldint c%0d", c), e_g, e_a, e_wen, chk_d, e_d, e_rd);
            @(posedge clk);
            #1;
            if (saw_spi) done++;
            if (saw_ld) ld_done++;
        end
        drive_idle();

        check("sb drain", 32'(exp_q.size()), 32'(0));

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
